// File: rtl/rv32i_types.sv
// Shared RV32I fetch-side types.
//   rv32i_word     : 32-bit architectural word (PCs, instructions)
//   fetch_entry_t  : one prefetch queue entry {pc, instr}
//   fetch_state_e  : state of the single outstanding I-side read
//   next_seq_pc()  : sequential PC step, wraps modulo 2^32
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef struct packed {
      rv32i_word pc;
      rv32i_word instr;
   } fetch_entry_t;

   // StRead: read outstanding, response will be queued.
   // StDrop: read outstanding, but a redirect made it stale; response is discarded.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRead = 2'b01,
      StDrop = 2'b10
   } fetch_state_e;

   localparam rv32i_word InstrBytes = 32'd4;

   function automatic rv32i_word next_seq_pc(input rv32i_word pc);
      return pc + InstrBytes;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding prefetched fetch entries.
//   clk, reset_n : clock, asynchronous active-low reset
//   push_i/data_i: write one entry (ignored when full unless popping the same cycle)
//   pop_i        : advance the head (ignored when empty)
//   flush_i      : empty the FIFO; wins over push and pop
//   head_o       : entry at the head (meaningful only when !empty_o)
//   empty_o      : no entries held
//   count_o      : number of entries held
module fetch_fifo
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type T = fetch_entry_t,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  T              data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output T              head_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == FullCount);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & (~full | do_pop) & ~flush_i;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // The issue logic upstream guarantees space before requesting.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with a sequential prefetch queue.
// Owns the PC, keeps at most one I-side read outstanding, queues {pc, instr}
// for decode and restarts at redirect_pc on a taken branch/jump.
//   clk, reset_n         : clock, asynchronous active-low reset
//   imem_read/_address   : read request, held with a stable address until imem_resp
//   imem_rdata/_resp     : response data and its 1-cycle completion pulse
//   redirect_valid/_pc   : 1-cycle redirect from execute and its target
//   out_valid/_ready     : decode handshake on the queue head
//   out_pc/out_instr     : queue head contents
//   occupancy            : entries currently queued
module fetch_prefetch_queue
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter rv32i_word   RESET_PC = 32'h0,
   localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic          imem_read,
   output rv32i_word     imem_address,
   input  rv32i_word     imem_rdata,
   input  logic          imem_resp,
   input  logic          redirect_valid,
   input  rv32i_word     redirect_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output rv32i_word     out_pc,
   output rv32i_word     out_instr,
   output logic [CW-1:0] occupancy
);

   localparam int unsigned LW = CW + 1;
   localparam logic [LW-1:0] DepthLevel = LW'(DEPTH);

   fetch_state_e  state_q, state_d;
   rv32i_word     pc_q, pc_d;
   rv32i_word     addr_q, addr_d;

   logic          inflight;
   logic          drop;
   logic          resp_live;
   logic          push;
   logic          pop;
   logic          issue;
   logic          fifo_empty;
   logic [CW-1:0] count;
   logic [LW-1:0] fill_level;
   fetch_entry_t  push_entry;
   fetch_entry_t  head_entry;

   assign inflight  = (state_q != StIdle);
   assign drop      = (state_q == StDrop);
   // A response with nothing outstanding (e.g. left over across a reset) is ignored.
   assign resp_live = imem_resp & inflight;
   assign push      = resp_live & ~drop & ~redirect_valid;
   assign pop       = out_valid & out_ready;

   // Entries held plus the one that may be in flight, less the head leaving now, so a
   // full queue can issue in the cycle right after decode frees a slot.
   assign fill_level = {1'b0, count} + LW'(inflight) - LW'(pop);
   assign issue      = ~inflight & ~redirect_valid & (fill_level < DepthLevel);

   assign push_entry.pc    = addr_q;
   assign push_entry.instr = imem_rdata;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StRead;
               addr_d  = pc_q;
            end
         end
         StRead: begin
            if (imem_resp) begin
               state_d = StIdle;
               pc_d    = next_seq_pc(pc_q);
            end else if (redirect_valid) begin
               // Reads cannot be aborted: keep the request up and discard its data.
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (imem_resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Newest redirect always wins the PC; misaligned targets pass through untouched.
      if (redirect_valid) pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .head_o  (head_entry),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   assign imem_read    = inflight;
   assign imem_address = addr_q;
   assign out_valid    = ~fifo_empty;
   assign out_pc       = head_entry.pc;
   assign out_instr    = head_entry.instr;
   assign occupancy    = count;

endmodule
